// File: rtl/jtgng_dpram_clr.sv
// jtgng_dpram_clr: dual-port RAM that sweeps every word to CLRVAL after reset or a clr request
//   clk, rst_n (async, active-low), cen gates every state change
//   clr restarts the sweep; busy is high while sweeping
//   port A/B: addr_x, data_x, we_x (byte strobes when BE=1) -> q_x (1 or 2 cen-cycle latency)
module jtgng_dpram_clr #(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int BE = 0,
    parameter int OUTREG = 0,
    parameter logic [DW-1:0] CLRVAL = '0,
    parameter int WBW = BE ? DW/8 : 1
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           clr,
    output logic           busy,
    input  logic [AW-1:0]  addr_a,
    input  logic [DW-1:0]  data_a,
    input  logic [WBW-1:0] we_a,
    output logic [DW-1:0]  q_a,
    input  logic [AW-1:0]  addr_b,
    input  logic [DW-1:0]  data_b,
    input  logic [WBW-1:0] we_b,
    output logic [DW-1:0]  q_b
);
    // strobe lane width: one byte with byte enables, otherwise the whole word
    localparam int LW = BE ? 8 : DW;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [DW-1:0] mem [0:2**AW-1];
    logic [DW-1:0] ra, rb, pa, pb;

    assign busy = state == CLEAR;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (cen) begin
            if (clr) begin
                state_nx = CLEAR;
                cnt_nx   = '0;
            end else if (state == CLEAR) begin
                cnt_nx = cnt + 1'b1;
                if (&cnt) state_nx = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // port B is written first so port A overrides it on overlapping lanes
    always_ff @(posedge clk) begin
        if (cen) begin
            if (state == CLEAR) begin
                mem[cnt] <= CLRVAL;
            end else begin
                for (int i = 0; i < WBW; i++) begin
                    if (we_b[i]) mem[addr_b][i*LW +: LW] <= data_b[i*LW +: LW];
                    if (we_a[i]) mem[addr_a][i*LW +: LW] <= data_a[i*LW +: LW];
                end
            end
        end
    end

    // reads sample mem before this edge's writes land, giving read-first behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
            pa <= '0;
            pb <= '0;
        end else if (cen) begin
            ra <= state == RUN ? mem[addr_a] : '0;
            rb <= state == RUN ? mem[addr_b] : '0;
            pa <= ra;
            pb <= rb;
        end
    end

    // outputs are forced to zero for the whole sweep, including its first cycle
    assign q_a = busy ? '0 : (OUTREG != 0 ? pa : ra);
    assign q_b = busy ? '0 : (OUTREG != 0 ? pb : rb);
endmodule

// File: tb/tb_jtgng_dpram_clr.sv
// tb_jtgng_dpram_clr: scoreboard bench for jtgng_dpram_clr (DW=16, AW=4, BE=1, OUTREG=0)
module tb_jtgng_dpram_clr;
    localparam logic [15:0] CV = 16'hC1A5;
    localparam int SEL_BUSY = 0, SEL_QA = 1, SEL_QB = 2;

    logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, clr = 1'b0, busy;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [15:0] data_a = '0, data_b = '0, q_a, q_b;
    logic [1:0]  we_a = '0, we_b = '0;

    int cyc = 0, errors = 0, checks = 0;

    typedef struct {
        int          at;
        int          sel;
        logic [15:0] val;
        string       name;
    } chk_t;
    chk_t sb[$];

    jtgng_dpram_clr #(.DW(16), .AW(4), .BE(1), .OUTREG(0), .CLRVAL(CV)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .clr(clr), .busy(busy),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // monitor: compares every expectation due on this cycle, away from the rising edge
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                logic [15:0] act;
                act = sb[i].sel == SEL_BUSY ? {15'b0, busy} : (sb[i].sel == SEL_QA ? q_a : q_b);
                checks++;
                if (sb[i].at < cyc || act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic chk(input int d, input int sel, input logic [15:0] v, input string nm);
        sb.push_back('{cyc + d, sel, v, nm});
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic [3:0] aa, input logic [15:0] da, input logic [1:0] wa,
                       input logic [3:0] ab, input logic [15:0] db, input logic [1:0] wb);
        addr_a = aa; data_a = da; we_a = wa;
        addr_b = ab; data_b = db; we_b = wb;
    endtask

    initial begin
        // reset state
        step();
        chk(0, SEL_BUSY, 16'd1, "rst_busy");
        chk(0, SEL_QA, 16'h0, "rst_qa");
        chk(0, SEL_QB, 16'h0, "rst_qb");
        step();
        // power-up sweep: 16 cycles of busy
        rst_n = 1'b1;
        for (int d = 1; d <= 16; d++) chk(d, SEL_BUSY, {15'b0, d < 16}, "sweep_busy");
        step(16);
        for (int i = 0; i < 16; i++) begin
            drv(4'(i), 16'h0, 2'b00, 4'(15 - i), 16'h0, 2'b00);
            chk(1, SEL_QA, CV, "init_qa");
            chk(1, SEL_QB, CV, "init_qb");
            step();
        end
        // byte-strobe merge with read-first on the same cycle
        drv(4'd3, 16'h1234, 2'b11, 4'd0, 16'h0, 2'b00);
        step();
        drv(4'd3, 16'hABCD, 2'b01, 4'd0, 16'h0, 2'b00);
        chk(1, SEL_QA, 16'h1234, "be_readfirst");
        step();
        drv(4'd3, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        chk(1, SEL_QA, 16'h12CD, "be_merge");
        step();
        // cen=0: write and clr ignored, outputs hold
        cen = 1'b0; clr = 1'b1;
        drv(4'd3, 16'hFFFF, 2'b11, 4'd0, 16'h0, 2'b00);
        chk(1, SEL_QA, 16'h12CD, "cen0_hold");
        chk(1, SEL_BUSY, 16'd0, "cen0_noclr");
        step();
        cen = 1'b1; clr = 1'b0;
        drv(4'd3, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        chk(1, SEL_QA, 16'h12CD, "cen0_nowrite");
        step();
        // cross-port read-first
        drv(4'd0, 16'h0, 2'b00, 4'd7, 16'h0011, 2'b11);
        step();
        drv(4'd7, 16'h0055, 2'b11, 4'd7, 16'h0, 2'b00);
        chk(1, SEL_QB, 16'h0011, "xport_old");
        step();
        drv(4'd0, 16'h0, 2'b00, 4'd7, 16'h0, 2'b00);
        chk(1, SEL_QB, 16'h0055, "xport_new");
        step();
        // same-address collisions
        drv(4'd2, 16'hAAAA, 2'b11, 4'd2, 16'hBBBB, 2'b11);
        step();
        drv(4'd2, 16'h0, 2'b00, 4'd2, 16'h0, 2'b00);
        chk(1, SEL_QA, 16'hAAAA, "coll_full");
        step();
        drv(4'd2, 16'h1111, 2'b01, 4'd2, 16'h2222, 2'b11);
        step();
        drv(4'd2, 16'h0, 2'b00, 4'd2, 16'h0, 2'b00);
        chk(1, SEL_QB, 16'h2211, "coll_bytes");
        step();
        // clr in RUN restarts the sweep; writes during busy are lost
        drv(4'd5, 16'h0077, 2'b11, 4'd0, 16'h0, 2'b00);
        step();
        drv(4'd5, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        clr = 1'b1;
        chk(1, SEL_QA, 16'h0, "clr_q_zero");
        for (int d = 1; d <= 17; d++) chk(d, SEL_BUSY, {15'b0, d <= 16}, "clr_busy");
        step();
        clr = 1'b0;
        drv(4'd9, 16'h9999, 2'b11, 4'd10, 16'h8888, 2'b11);
        step();
        drv(4'd0, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        step(15);
        drv(4'd5, 16'h0, 2'b00, 4'd9, 16'h0, 2'b00);
        chk(1, SEL_QA, CV, "clr_addr5");
        chk(1, SEL_QB, CV, "clr_lost_wr");
        step();
        drv(4'd10, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        chk(1, SEL_QA, CV, "clr_lost_wrb");
        step();
        // reset mid-sweep, then a full sweep with cen toggling
        drv(4'd5, 16'h0077, 2'b11, 4'd0, 16'h0, 2'b00);
        step();
        drv(4'd0, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step(4);
        rst_n = 1'b0;
        chk(0, SEL_BUSY, 16'd1, "midrst_busy");
        chk(0, SEL_QB, 16'h0, "midrst_qb");
        step();
        rst_n = 1'b1;
        for (int d = 1; d <= 31; d++) chk(d, SEL_BUSY, {15'b0, d <= 30}, "cen_busy");
        for (int j = 0; j < 32; j++) begin
            cen = (j % 2) == 0;
            step();
        end
        cen = 1'b1;
        drv(4'd5, 16'h0, 2'b00, 4'd0, 16'h0, 2'b00);
        chk(1, SEL_QA, CV, "rst_addr5");
        chk(1, SEL_QB, CV, "rst_addr0");
        step();
        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtgng_dpram_clr.md
JTGNG_DPRAM_CLR -- requirements
Module: jtgng_dpram_clr

Interface
REQ-001 SHALL have parameter DW, default 8: data width in bits; when BE=1 it SHALL be a multiple of 8.
REQ-002 SHALL have parameter AW, default 10: address width; depth is 2**AW words.
REQ-003 SHALL have parameter BE, default 0: 1 enables per-byte write strobes; 0 means a single strobe covers the whole word.
REQ-004 SHALL have parameter OUTREG, default 0: 1 adds one output register stage to both ports.
REQ-005 SHALL have parameter CLRVAL, default 0 (DW bits): word value written by the clear sweep.
REQ-006 SHALL have parameter WBW = BE ? DW/8 : 1, derived (not user-set): write-strobe width.
REQ-007 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 cen  in  1  clock enable gating all state changes, sweep steps and output updates.
REQ-010 clr  in  1  one-cycle request to restart the clear sweep.
REQ-011 busy  out  1  high while the clear sweep is in progress.
REQ-012 addr_a  in  AW  port A address.
REQ-013 data_a  in  DW  port A write data.
REQ-014 we_a  in  WBW  port A write strobes; bit i covers data_a[8i+7:8i] when BE=1.
REQ-015 q_a  out  DW  port A read data.
REQ-016 addr_b, data_b, we_b, q_b  in/in/in/out  AW/DW/WBW/DW  port B, defined identically to port A.

Function
REQ-017 FSM SHALL have two states: CLEAR and RUN.
REQ-018 CLEAR: on each cycle with cen=1, SHALL write CLRVAL to mem[cnt] and then increment cnt.
REQ-019 CLEAR: when a cen=1 step writes address 2**AW-1, the FSM SHALL move to RUN and cnt SHALL wrap to 0.
REQ-020 busy SHALL equal (state==CLEAR), so a full sweep takes exactly 2**AW cen-cycles.
REQ-021 RUN: clr=1 with cen=1 SHALL set state=CLEAR and cnt=0; the first sweep write SHALL occur on the next cen=1 cycle.
REQ-022 clr=1 during CLEAR SHALL restart the sweep at cnt=0.
REQ-023 During CLEAR, all port writes SHALL be discarded, and q_a and q_b SHALL hold 0.
REQ-024 RUN, cen=1: each port SHALL write the bytes (or the whole word) selected by its strobes at its address.
REQ-025 RUN, cen=1: each port SHALL register mem[addr] as read data.
REQ-026 Reads SHALL be read-first: a read of an address written in the same cycle, by either port, SHALL return the old data.
REQ-027 Read latency SHALL be 1 cen-cycle when OUTREG=0, and 2 cen-cycles when OUTREG=1.
REQ-028 The OUTREG stage SHALL advance only when cen=1.
REQ-029 If both ports write the same address in the same cycle, port A bytes SHALL win wherever strobes overlap; non-overlapping port B bytes SHALL still be written.
REQ-030 With cen=0, memory, FSM, cnt and outputs SHALL hold; clr SHALL be ignored.
REQ-031 Address arithmetic SHALL be modulo 2**AW; cnt SHALL be AW bits wide.

Reset
REQ-032 While rst_n=0: state=CLEAR, cnt=0, busy=1, q_a=0, q_b=0, all pipeline registers=0.
REQ-033 Memory contents SHALL NOT be affected by rst_n; only the sweep initialises memory.
REQ-034 Reset asserted mid-sweep or mid-RUN SHALL abort immediately, and a full sweep SHALL restart from address 0 after release.
REQ-035 After rst_n rises, the first sweep write SHALL occur on the first cen=1 edge.

Verification
REQ-036 AW=4, cen=1, release reset -> busy high for exactly 16 cycles; afterwards reads of all 16 addresses return CLRVAL.
REQ-037 DW=16, BE=1, RUN: write 0x1234 to addr 3, then we_a=2'b01 with data 0xABCD -> read returns 0x12CD one cycle later (two cycles later with OUTREG=1).
REQ-038 Same cycle: A writes 0x55 to addr 7, B reads addr 7 holding 0x11 -> q_b=0x11; the next read returns 0x55.
REQ-039 Same cycle: A writes 0xAA and B writes 0xBB to addr 2, both full strobes -> mem[2]=0xAA; with BE=1, we_a=01 and we_b=11 -> low byte from A, high byte from B.
REQ-040 cen toggling 1/0 during the sweep -> busy lasts 2**AW cen-high cycles; cnt and q do not change on cen=0 cycles.
REQ-041 Pulse clr in RUN after writing 0x77 to addr 5, and assert rst_n=0 mid-sweep -> each restarts at addr 0; addr 5 reads CLRVAL after busy falls; port writes attempted during busy are lost.
